// File: rtl/unidade_funcional_param_if.sv
// Issue/result handshake bundle for the multi-cycle functional unit.
// The reservation station drives the master side; the unit implements the slave side.
interface unidade_funcional_param_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ulaop;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [TAG_W-1:0] tag_out;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, ulaop, a, b, tag_in, out_ready,
    input  in_ready, out_valid, q, tag_out, ovf, busy
  );

  modport slave (
    input  in_valid, ulaop, a, b, tag_in, out_ready,
    output in_ready, out_valid, q, tag_out, ovf, busy
  );
endinterface

// File: rtl/unidade_funcional_param.sv
// Multi-cycle integer functional unit: one tagged operation in flight, iterative
// shift-add multiply, result held until the common data bus grants it.
module unidade_funcional_param #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 3,
  parameter int LAT   = 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  unidade_funcional_param_if.slave fu
);
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_CMP  = 3'b011;
  localparam logic [2:0] OP_ADD4 = 3'b100;
  localparam logic [2:0] OP_SUB4 = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_SLTS = 3'b111;

  localparam int CNT_MAX = (WIDTH > LAT) ? WIDTH : LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int MSB     = WIDTH - 1;
  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [TAG_W-1:0] tag_reg, tag_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [TAG_W-1:0] tag_out_reg, tag_out_next;
  logic             ovf_reg, ovf_next;

  logic [WIDTH-1:0] sum, diff, b_plus4, b_minus4;
  logic [WIDTH-1:0] addend, acc_step, alu_q;
  logic             alu_ovf;

  assign sum      = a_reg + b_reg;
  assign diff     = a_reg - b_reg;
  assign b_plus4  = b_reg + FOUR;
  assign b_minus4 = b_reg - FOUR;

  // During MUL, a_reg is the left-shifting multiplicand and b_reg the right-shifting multiplier.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_partial
      assign addend[gi] = a_reg[gi] & b_reg[0];
    end
  endgenerate

  assign acc_step = acc_reg + addend;

  always_comb begin
    alu_q   = sum;
    alu_ovf = 1'b0;
    case (op_reg)
      OP_ADD: begin
        alu_q   = sum;
        alu_ovf = (a_reg[MSB] == b_reg[MSB]) && (sum[MSB] != a_reg[MSB]);
      end
      OP_SUB: begin
        alu_q   = diff;
        alu_ovf = (a_reg[MSB] != b_reg[MSB]) && (diff[MSB] != a_reg[MSB]);
      end
      OP_SLT:  alu_q = (a_reg < b_reg) ? ONE : '0;
      OP_CMP:  alu_q = (a_reg == b_reg) ? ONE : '0;
      OP_ADD4: begin
        alu_q   = b_plus4;
        alu_ovf = !b_reg[MSB] && b_plus4[MSB];
      end
      OP_SUB4: begin
        alu_q   = b_minus4;
        alu_ovf = b_reg[MSB] && !b_minus4[MSB];
      end
      OP_MUL:  alu_q = acc_step;
      OP_SLTS: alu_q = ($signed(a_reg) < $signed(b_reg)) ? ONE : '0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    op_next      = op_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    acc_next     = acc_reg;
    tag_next     = tag_reg;
    q_next       = q_reg;
    tag_out_next = tag_out_reg;
    ovf_next     = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (fu.in_valid) begin
          op_next    = fu.ulaop;
          a_next     = fu.a;
          b_next     = fu.b;
          tag_next   = fu.tag_in;
          acc_next   = '0;
          count_next = (fu.ulaop == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(LAT);
          state_next = EXEC;
        end
      end
      EXEC: begin
        count_next = count_reg - CNT_W'(1);
        if (op_reg == OP_MUL) begin
          acc_next = acc_step;
          a_next   = a_reg << 1;
          b_next   = b_reg >> 1;
        end
        // The last EXEC cycle includes the final multiply step, hence alu_q uses acc_step.
        if (count_reg == CNT_W'(1)) begin
          q_next       = alu_q;
          ovf_next     = alu_ovf;
          tag_out_next = tag_reg;
          state_next   = DONE;
        end
      end
      DONE: begin
        if (fu.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_reg   <= '0;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      tag_reg     <= '0;
      q_reg       <= '0;
      tag_out_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      count_reg   <= count_next;
      op_reg      <= op_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      acc_reg     <= acc_next;
      tag_reg     <= tag_next;
      q_reg       <= q_next;
      tag_out_reg <= tag_out_next;
      ovf_reg     <= ovf_next;
    end
  end

  assign fu.in_ready  = (state_reg == IDLE);
  assign fu.busy      = (state_reg != IDLE);
  assign fu.out_valid = (state_reg == DONE);
  assign fu.q         = q_reg;
  assign fu.tag_out   = tag_out_reg;
  assign fu.ovf       = ovf_reg;
endmodule
